// File: rtl/zero_comp_pkg.sv
// Shared constants, result encoding and helpers for the zero_comp_32bit comparator.
// The optional event counters are enabled with the ZERO_COMP_CNT_EN macro.
package zero_comp_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    RES_EQ  = 2'd0,
    RES_BG  = 2'd1,
    RES_LES = 2'd2
  } result_e;

  function automatic result_e classify(input logic bg, input logic les);
    if (les) begin
      return RES_LES;
    end else if (bg) begin
      return RES_BG;
    end else begin
      return RES_EQ;
    end
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/zero_comp_core.sv
// Stateless signed sign/zero classifier: exactly one of bg/les/eq is high.
module zero_comp_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] number,
  output logic             bg,
  output logic             les,
  output logic             eq
);

  assign les = number[WIDTH-1];
  assign eq  = ~|number;
  assign bg  = ~les & ~eq;

endmodule

// File: rtl/zero_comp_32bit.sv
// Registered signed comparison of number against zero, one cycle latency.
// Define ZERO_COMP_CNT_EN to add saturating per-result counters with cnt_clr.
module zero_comp_32bit
  import zero_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] number,
`ifdef ZERO_COMP_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_bg,
  output logic [CNT_W-1:0] cnt_les,
  output logic [CNT_W-1:0] cnt_eq,
`endif
  output logic             out_valid,
  output logic             bg,
  output logic             les,
  output logic             eq
);

  // Handshake: in_valid has no ready; each sampled in_valid yields out_valid
  // on the next cycle. Idle cycles drop out_valid but keep the last flags.
  logic core_bg, core_les, core_eq;

  zero_comp_core #(.WIDTH(WIDTH)) u_core (
    .number (number),
    .bg     (core_bg),
    .les    (core_les),
    .eq     (core_eq)
  );

  logic out_valid_d, out_valid_q;
  logic bg_d, bg_q;
  logic les_d, les_q;
  logic eq_d, eq_q;

  always_comb begin
    out_valid_d = in_valid;
    bg_d        = bg_q;
    les_d       = les_q;
    eq_d        = eq_q;
    if (in_valid) begin
      bg_d  = core_bg;
      les_d = core_les;
      eq_d  = core_eq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bg_q        <= 1'b0;
      les_q       <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      bg_q        <= bg_d;
      les_q       <= les_d;
      eq_q        <= eq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bg        = bg_q;
  assign les       = les_q;
  assign eq        = eq_q;

`ifdef ZERO_COMP_CNT_EN
  result_e          res;
  logic [CNT_W-1:0] cnt_bg_d, cnt_bg_q;
  logic [CNT_W-1:0] cnt_les_d, cnt_les_q;
  logic [CNT_W-1:0] cnt_eq_d, cnt_eq_q;

  // Clear wins over a same-cycle increment.
  always_comb begin
    res       = classify(core_bg, core_les);
    cnt_bg_d  = cnt_bg_q;
    cnt_les_d = cnt_les_q;
    cnt_eq_d  = cnt_eq_q;
    if (cnt_clr) begin
      cnt_bg_d  = '0;
      cnt_les_d = '0;
      cnt_eq_d  = '0;
    end else if (in_valid) begin
      case (res)
        RES_BG:  cnt_bg_d  = sat_inc(cnt_bg_q);
        RES_LES: cnt_les_d = sat_inc(cnt_les_q);
        RES_EQ:  cnt_eq_d  = sat_inc(cnt_eq_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_bg_q  <= '0;
      cnt_les_q <= '0;
      cnt_eq_q  <= '0;
    end else begin
      cnt_bg_q  <= cnt_bg_d;
      cnt_les_q <= cnt_les_d;
      cnt_eq_q  <= cnt_eq_d;
    end
  end

  assign cnt_bg  = cnt_bg_q;
  assign cnt_les = cnt_les_q;
  assign cnt_eq  = cnt_eq_q;
`endif

endmodule

// File: tb/tb_zero_comp_32bit.sv
// Self-checking bench for zero_comp_32bit: directed scenarios plus random traffic
// against a signed-arithmetic reference model. Covers counters when ZERO_COMP_CNT_EN is set.
module tb_zero_comp_32bit;

`ifdef ZERO_COMP_CNT_EN
  localparam int EW = 52;
`else
  localparam int EW = 4;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] number;
  logic        out_valid, bg, les, eq;
`ifdef ZERO_COMP_CNT_EN
  logic        cnt_clr;
  logic [15:0] cnt_bg, cnt_les, cnt_eq;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [EW-1:0] exp_q[$];

  // model state
  bit m_valid, m_bg, m_les, m_eq;
  int m_cnt_bg, m_cnt_les, m_cnt_eq;

  zero_comp_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .number    (number),
`ifdef ZERO_COMP_CNT_EN
    .cnt_clr   (cnt_clr),
    .cnt_bg    (cnt_bg),
    .cnt_les   (cnt_les),
    .cnt_eq    (cnt_eq),
`endif
    .out_valid (out_valid),
    .bg        (bg),
    .les       (les),
    .eq        (eq)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [EW-1:0] pack_act();
`ifdef ZERO_COMP_CNT_EN
    return {out_valid, bg, les, eq, cnt_bg, cnt_les, cnt_eq};
`else
    return {out_valid, bg, les, eq};
`endif
  endfunction

  // reference model: signed arithmetic on the sampled operand
  task automatic model_step();
    int signed s;
    bit clr;
    s = $signed(number);
`ifdef ZERO_COMP_CNT_EN
    clr = cnt_clr;
`else
    clr = 1'b0;
`endif
    if (!rst_n) begin
      m_valid = 0; m_bg = 0; m_les = 0; m_eq = 0;
      m_cnt_bg = 0; m_cnt_les = 0; m_cnt_eq = 0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_bg  = (s > 0);
        m_les = (s < 0);
        m_eq  = (s == 0);
      end
      if (clr) begin
        m_cnt_bg = 0; m_cnt_les = 0; m_cnt_eq = 0;
      end else if (in_valid) begin
        if (s > 0 && m_cnt_bg < 65535) m_cnt_bg++;
        if (s < 0 && m_cnt_les < 65535) m_cnt_les++;
        if (s == 0 && m_cnt_eq < 65535) m_cnt_eq++;
      end
    end
  endtask

  function automatic logic [EW-1:0] pack_exp();
`ifdef ZERO_COMP_CNT_EN
    return {m_valid, m_bg, m_les, m_eq, m_cnt_bg[15:0], m_cnt_les[15:0], m_cnt_eq[15:0]};
`else
    return {m_valid, m_bg, m_les, m_eq};
`endif
  endfunction

  // scoreboard: model updates on each edge, outputs compared 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      exp_q.push_back(pack_exp());
      #1;
      check("cycle_outputs", 64'(pack_act()), 64'(exp_q.pop_front()));
      if (out_valid) check("one_hot", 64'($countones({bg, les, eq})), 64'd1);
    end
  end

  // driver: called at a negedge; returns at the next negedge with the result visible
  task automatic step(input logic v, input logic [31:0] n);
    in_valid = v;
    number   = n;
    @(negedge clk);
  endtask

  task automatic check_flags(input string name, input logic v, input logic b, input logic l, input logic e);
    check(name, {60'd0, out_valid, bg, les, eq}, {60'd0, v, b, l, e});
  endtask

  initial begin
    logic [31:0] bnd [4];
    logic [2:0]  bexp [4];
    bnd[0] = 32'h8000_0000; bexp[0] = 3'b010;
    bnd[1] = 32'h7FFF_FFFF; bexp[1] = 3'b100;
    bnd[2] = 32'hFFFF_FFFF; bexp[2] = 3'b010;
    bnd[3] = 32'h0000_0001; bexp[3] = 3'b100;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    number   = 32'd5;
`ifdef ZERO_COMP_CNT_EN
    cnt_clr  = 1'b0;
`endif
    // reset with a pending transaction: must be discarded
    @(negedge clk);
    check_flags("reset_c1", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_flags("reset_c2", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 32'd5);
    check_flags("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // sequence
    step(1'b1, 32'h0000_0000);
    check_flags("seq_zero", 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h0008_2003);
    check_flags("seq_pos", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hF032_2092);
    check_flags("seq_neg", 1'b1, 1'b0, 1'b1, 1'b0);

    // boundaries back-to-back
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bnd[i]);
      check_flags($sformatf("boundary_%0d", i), 1'b1, bexp[i][2], bexp[i][1], bexp[i][0]);
    end

    // hold
    step(1'b1, 32'hFFFF_FFF9);
    check_flags("hold_load", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom());
      check_flags($sformatf("hold_%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // random traffic with occasional resets and clears
    for (int i = 0; i < 400; i++) begin
      logic [31:0] n;
      case ($urandom_range(0, 5))
        0: n = 32'd0;
        1: n = 32'h8000_0000;
        2: n = 32'h7FFF_FFFF;
        3: n = $urandom_range(1, 3) * 32'hFFFF_FFFF;
        default: n = $urandom();
      endcase
      rst_n = ($urandom_range(0, 49) != 0);
`ifdef ZERO_COMP_CNT_EN
      cnt_clr = ($urandom_range(0, 19) == 0);
`endif
      step($urandom_range(0, 3) != 0, n);
    end
    rst_n = 1'b1;

`ifdef ZERO_COMP_CNT_EN
    cnt_clr = 1'b1;
    step(1'b0, 32'd0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 32'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 32'h8000_0010);
    check("cnt_eq_3", 64'(cnt_eq), 64'd3);
    check("cnt_les_2", 64'(cnt_les), 64'd2);
    check("cnt_bg_0", 64'(cnt_bg), 64'd0);
    cnt_clr = 1'b1;
    step(1'b1, 32'd0);
    cnt_clr = 1'b0;
    check("clr_priority", {16'd0, cnt_bg, cnt_les, cnt_eq}, 64'd0);
    for (int i = 0; i < 65536; i++) step(1'b1, 32'd7);
    check("cnt_bg_sat", 64'(cnt_bg), 64'hFFFF);
    step(1'b1, 32'd9);
    check("cnt_bg_sat_hold", 64'(cnt_bg), 64'hFFFF);
`endif

    step(1'b0, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
